// File: rtl/rib_arbiter_if.sv
// Master/slave bus bundle for rib_arbiter: four requesters in, one slave port out.
interface rib_arbiter_if;
  logic [3:0]   m_req_i;
  logic [3:0]   m_we_i;
  logic [127:0] m_addr_i;
  logic [127:0] m_wdata_i;
  logic [3:0]   m_gnt_o;
  logic [31:0]  m_rdata_o;
  logic [31:0]  s_addr_o;
  logic [31:0]  s_wdata_o;
  logic [3:0]   s_we_o;
  logic [127:0] s_rdata_i;
  logic         hold_flag_o;

  modport master (
    output m_req_i, m_we_i, m_addr_i, m_wdata_i, s_rdata_i,
    input  m_gnt_o, m_rdata_o, s_addr_o, s_wdata_o, s_we_o, hold_flag_o
  );

  modport slave (
    input  m_req_i, m_we_i, m_addr_i, m_wdata_i, s_rdata_i,
    output m_gnt_o, m_rdata_o, s_addr_o, s_wdata_o, s_we_o, hold_flag_o
  );
endinterface

// File: rtl/rib_arbiter.sv
// Four-master bus arbiter with lock-limited ownership and address-decoded slave mux.
// Define RIB_RR_EN for round-robin arbitration; default build is fixed priority 0>1>2>3.
module rib_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input logic          clk,
  input logic          rst,
  rib_arbiter_if.slave bus
);
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_owner, w_owner_nxt, w_win;
  logic [7:0]  r_lock, w_lock_nxt;
  logic [3:0]  r_excl, w_excl_nxt, w_elig, w_gnt;
  logic        w_busy, w_lock_hit, w_others, w_force;
  logic [31:0] w_addr;
  logic [3:0]  w_idx;
  logic        w_idx_ok;
`ifdef RIB_RR_EN
  logic [1:0]  r_ptr, w_ptr_nxt;
`endif

  // A lock-forced owner sits out the next arbitration so a waiting master gets in.
  assign w_elig = ((bus.m_req_i & ~r_excl) != 4'd0) ? (bus.m_req_i & ~r_excl) : bus.m_req_i;

  always_comb begin
    w_win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
`ifdef RIB_RR_EN
      if (w_elig[r_ptr + 2'(i)]) w_win = r_ptr + 2'(i);
`else
      if (w_elig[i]) w_win = 2'(i);
`endif
    end
  end

  assign w_busy     = (r_state == S_BUSY);
  assign w_gnt      = w_busy ? (4'd1 << r_owner) : 4'd0;
  assign w_lock_hit = (r_lock == LOCK_LAST);
  assign w_others   = ((bus.m_req_i & ~w_gnt) != 4'd0);
  assign w_force    = w_lock_hit && w_others;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= 2'd0;
      r_lock  <= 8'd0;
      r_excl  <= 4'd0;
`ifdef RIB_RR_EN
      r_ptr   <= 2'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_lock  <= w_lock_nxt;
      r_excl  <= w_excl_nxt;
`ifdef RIB_RR_EN
      r_ptr   <= w_ptr_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_lock_nxt  = r_lock;
    w_excl_nxt  = r_excl;
`ifdef RIB_RR_EN
    w_ptr_nxt   = r_ptr;
`endif
    case (r_state)
      S_IDLE: if (bus.m_req_i != 4'd0) begin
        w_state_nxt = S_BUSY;
        w_owner_nxt = w_win;
        w_lock_nxt  = 8'd0;
        w_excl_nxt  = 4'd0;
      end
      S_BUSY: if (!bus.m_req_i[r_owner] || w_force) begin
        w_state_nxt = S_IDLE;
        w_excl_nxt  = bus.m_req_i[r_owner] ? w_gnt : 4'd0;
`ifdef RIB_RR_EN
        w_ptr_nxt   = r_owner + 2'd1;
`endif
      end else if (!w_lock_hit) begin
        w_lock_nxt = r_lock + 8'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_addr   = bus.m_addr_i[{r_owner, 5'd0} +: 32];
  assign w_idx    = w_addr[31:28];
  assign w_idx_ok = (w_idx[3:2] == 2'd0);

  assign bus.m_gnt_o     = w_gnt;
  assign bus.s_addr_o    = w_busy ? w_addr : 32'd0;
  assign bus.s_wdata_o   = w_busy ? bus.m_wdata_i[{r_owner, 5'd0} +: 32] : 32'd0;
  assign bus.s_we_o      = (w_busy && w_idx_ok && bus.m_we_i[r_owner]) ? (4'd1 << w_idx[1:0]) : 4'd0;
  assign bus.m_rdata_o   = (w_busy && w_idx_ok) ? bus.s_rdata_i[{w_idx[1:0], 5'd0} +: 32] : 32'd0;
  assign bus.hold_flag_o = (bus.m_req_i[2] & ~w_gnt[2]) | (bus.m_req_i[3] & ~w_gnt[3]);
endmodule

// File: tb/tb_rib_arbiter.sv
// Scoreboard bench for rib_arbiter: per-cycle reference model feeds an expectation queue,
// a negedge monitor pops and compares; directed sequences cover the key scenarios.
module tb_rib_arbiter;
  localparam int LOCK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  rib_arbiter_if bus();
  rib_arbiter #(.LOCK_MAX(LOCK)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [3:0]  swe;
    logic [31:0] saddr;
    logic [31:0] swdata;
    logic [31:0] rdata;
    logic        hold;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: who owns the bus, how long it has held it, RR pointer,
  // and which master was forced off (it yields the next arbitration).
  bit         m_busy = 1'b0;
  int         m_owner = 0;
  int         m_run = 0;
  int         m_ptr = 0;
  logic [3:0] m_excl = 4'd0;

  logic [3:0]   n_req = '0, n_we = '0;
  logic [127:0] n_addr = '0, n_wdata = '0, n_rdata = '0;
  logic         n_rst = 1'b1;

  logic [3:0] g32 [12] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                           4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(logic [3:0] req, int ptr);
    for (int k = 0; k < 4; k++)
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    return 0;
  endfunction

  task automatic model_step();
    logic [3:0] req, elig, others;
    req = bus.m_req_i;
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_run = 0; m_ptr = 0; m_excl = 4'd0;
    end else if (!m_busy) begin
      if (req != 4'd0) begin
        elig = ((req & ~m_excl) != 4'd0) ? (req & ~m_excl) : req;
        m_owner = pick(elig, m_ptr);
        m_busy = 1'b1; m_run = 1; m_excl = 4'd0;
      end
    end else begin
      others = req & ~(4'(1 << m_owner));
      if (!req[m_owner] || (m_run >= LOCK && others != 4'd0)) begin
        m_busy = 1'b0;
        m_excl = req[m_owner] ? 4'(1 << m_owner) : 4'd0;
`ifdef RIB_RR_EN
        m_ptr = (m_owner + 1) % 4;
`endif
      end else begin
        m_run++;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   idx;
    e = '0;
    if (m_busy && !rst) begin
      e.gnt    = 4'(1 << m_owner);
      e.saddr  = bus.m_addr_i[m_owner*32 +: 32];
      e.swdata = bus.m_wdata_i[m_owner*32 +: 32];
      idx = int'(e.saddr >> 28);
      if (idx < 4) begin
        e.swe   = bus.m_we_i[m_owner] ? 4'(1 << idx) : 4'd0;
        e.rdata = bus.s_rdata_i[idx*32 +: 32];
      end
    end
    e.hold = (bus.m_req_i[2] && !e.gnt[2]) || (bus.m_req_i[3] && !e.gnt[3]);
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    rst           = n_rst;
    bus.m_req_i   = n_req;
    bus.m_we_i    = n_we;
    bus.m_addr_i  = n_addr;
    bus.m_wdata_i = n_wdata;
    bus.s_rdata_i = n_rdata;
    exp_q.push_back(model_out());
  endtask

  task automatic set_m(int k, logic we, logic [31:0] addr, logic [31:0] wdata);
    n_we[k] = we;
    n_addr[k*32 +: 32] = addr;
    n_wdata[k*32 +: 32] = wdata;
  endtask

  task automatic do_reset();
    n_req = 4'd0; n_rst = 1'b1; cyc();
    n_rst = 1'b0; cyc();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("mon_gnt",    32'(bus.m_gnt_o),     32'(e.gnt));
      chk("mon_s_we",   32'(bus.s_we_o),      32'(e.swe));
      chk("mon_s_addr", bus.s_addr_o,         e.saddr);
      chk("mon_s_wdat", bus.s_wdata_o,        e.swdata);
      chk("mon_rdata",  bus.m_rdata_o,        e.rdata);
      chk("mon_hold",   32'(bus.hold_flag_o), 32'(e.hold));
    end
  end

  initial begin
    bus.m_req_i = '0; bus.m_we_i = '0; bus.m_addr_i = '0;
    bus.m_wdata_i = '0; bus.s_rdata_i = '0;

    // Reset state with requests present.
    n_req = 4'b0011; n_rdata = {4{32'hFFFF_FFFF}};
    set_m(0, 1'b1, 32'h0000_0000, 32'h1111_1111);
    cyc(); cyc(); #2;
    chk("rst_gnt",   32'(bus.m_gnt_o), 32'd0);
    chk("rst_s_we",  32'(bus.s_we_o), 32'd0);
    chk("rst_saddr", bus.s_addr_o, 32'd0);
    chk("rst_swdat", bus.s_wdata_o, 32'd0);
    chk("rst_rdata", bus.m_rdata_o, 32'd0);
    chk("rst_hold",  32'(bus.hold_flag_o), 32'd0);
    do_reset();

    // m2 and m3 contend; m2 wins from a fresh reset in either arbitration mode.
    set_m(2, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
    set_m(3, 1'b0, 32'h0000_0010, 32'h0000_0001);
    n_rdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    n_req = 4'b1100; cyc(); #2;
    chk("r31_idle_gnt", 32'(bus.m_gnt_o), 32'd0);
    chk("r31_idle_hold", 32'(bus.hold_flag_o), 32'd1);
    cyc(); #2;
    chk("r31_gnt",   32'(bus.m_gnt_o), 32'b0100);
    chk("r31_s_we",  32'(bus.s_we_o), 32'b0010);
    chk("r31_swdat", bus.s_wdata_o, 32'hDEAD_BEEF);
    chk("r31_rdata", bus.m_rdata_o, 32'h2222_2222);
    chk("r31_hold",  32'(bus.hold_flag_o), 32'd1);
    n_req = 4'd0; cyc(); cyc();

    // Lock limit: m0 and m1 both held requesting.
    do_reset();
    set_m(0, 1'b0, 32'h0000_0100, 32'hA0A0_A0A0);
    set_m(1, 1'b1, 32'h1000_0200, 32'hB1B1_B1B1);
    n_req = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      cyc(); #2;
      chk($sformatf("r32_gnt_c%0d", c), 32'(bus.m_gnt_o), 32'(g32[c]));
    end
    n_req = 4'd0; cyc(); cyc();

`ifdef RIB_RR_EN
    // Round-robin rotation with each owner dropping after one BUSY cycle.
    do_reset();
    n_req = 4'b1111; cyc(); #2;
    chk("r33_idle0", 32'(bus.m_gnt_o), 32'd0);
    for (int j = 0; j < 5; j++) begin
      n_req = 4'b1111 & ~(4'(1 << (j % 4)));
      cyc(); #2;
      chk($sformatf("r33_gnt%0d", j), 32'(bus.m_gnt_o), 32'(1 << (j % 4)));
      n_req = 4'b1111;
      cyc(); #2;
      chk($sformatf("r33_idle%0d", j + 1), 32'(bus.m_gnt_o), 32'd0);
    end
    n_req = 4'd0; cyc(); cyc();
`endif

    // Out-of-range slave index: no strobe, no read data.
    do_reset();
    set_m(3, 1'b0, 32'h5000_0000, 32'h0BAD_0BAD);
    n_rdata = {4{32'hA5A5_5A5A}};
    n_req = 4'b1000; cyc(); cyc(); #2;
    chk("r34_gnt",   32'(bus.m_gnt_o), 32'b1000);
    chk("r34_saddr", bus.s_addr_o, 32'h5000_0000);
    chk("r34_rdata", bus.m_rdata_o, 32'd0);
    chk("r34_s_we",  32'(bus.s_we_o), 32'd0);
    set_m(3, 1'b1, 32'h5000_0000, 32'h0BAD_0BAD);
    cyc(); #2;
    chk("r34_s_we_wr", 32'(bus.s_we_o), 32'd0);
    n_req = 4'd0; cyc(); cyc();

    // Reset while m1 is writing.
    do_reset();
    set_m(1, 1'b1, 32'h2000_0008, 32'h1234_5678);
    n_req = 4'b0010; cyc(); cyc(); #2;
    chk("r35_gnt_pre",  32'(bus.m_gnt_o), 32'b0010);
    chk("r35_s_we_pre", 32'(bus.s_we_o), 32'b0100);
    n_rst = 1'b1; cyc(); #2;
    chk("r35_gnt_rst",  32'(bus.m_gnt_o), 32'd0);
    chk("r35_s_we_rst", 32'(bus.s_we_o), 32'd0);
    n_rst = 1'b0; cyc(); #2;
    chk("r35_gnt_rel", 32'(bus.m_gnt_o), 32'd0);
    cyc(); #2;
    chk("r35_regnt", 32'(bus.m_gnt_o), 32'b0010);
    n_req = 4'd0; cyc(); cyc();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 4) == 0) n_req[k] = ~n_req[k];
        set_m(k, 1'($urandom_range(0, 1)),
              {4'($urandom_range(0, 5)), 28'($urandom)}, 32'($urandom));
      end
      n_rdata = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      n_rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    n_rst = 1'b0; n_req = 4'd0;
    cyc(); cyc(); cyc();
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rib_arbiter.md
RIB_ARBITER -- requirements
Module: rib_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 16, meaning the maximum consecutive BUSY cycles for one owner while another master requests (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port m_req_i, input, 4, per-master request; master 0 is jtag, 1 is uart debug, 2 is core ex, 3 is core pc fetch.
REQ-005 SHALL have port m_we_i, input, 4, per-master write enable.
REQ-006 SHALL have port m_addr_i, input, 128, packed addresses; master k is bits [32k+31:32k].
REQ-007 SHALL have port m_wdata_i, input, 128, packed write data, same packing.
REQ-008 SHALL have port m_gnt_o, output, 4, one-hot registered grant.
REQ-009 SHALL have port m_rdata_o, output, 32, read data returned to the current owner.
REQ-010 SHALL have port s_addr_o, output, 32, address forwarded to the slaves.
REQ-011 SHALL have port s_wdata_o, output, 32, write data forwarded to the slaves.
REQ-012 SHALL have port s_we_o, output, 4, one-hot per-slave write strobe.
REQ-013 SHALL have port s_rdata_i, input, 128, packed slave read data; slave j is bits [32j+31:32j].
REQ-014 SHALL have port hold_flag_o, output, 1, core stall request.

Function
REQ-015 SHALL implement a 2-state FSM:
- IDLE: no owner.
- BUSY: owner register valid; m_gnt_o is the one-hot of the owner.
REQ-016 IDLE with any m_req_i bit set SHALL select the winner per REQ-026/027, load the owner, and enter BUSY on the next edge; grant latency is 1 cycle after request.
REQ-017 BUSY SHALL return to IDLE on the next edge when the owner's m_req_i is 0. The release cycle has all-zero m_gnt_o, so back-to-back owners are separated by exactly one IDLE cycle.
REQ-018 BUSY SHALL use an 8-bit lock counter:
- the counter is cleared on entry to BUSY and increments each BUSY cycle;
- when it equals LOCK_MAX-1 and any non-owner request is set, the FSM SHALL force IDLE on the next edge;
- with no competing request the counter saturates and the owner keeps the grant.
REQ-019 SHALL decode the slave index from s_addr_o[31:28]; the valid range is 0..3.
REQ-020 In BUSY, the outputs SHALL be combinational from the owner:
- s_addr_o and s_wdata_o carry the owner's fields;
- s_we_o[idx] = owner m_we_i, and all other bits are 0;
- m_rdata_o = s_rdata_i[idx].
REQ-021 An index of 4..15 SHALL give s_we_o = 0 and m_rdata_o = 0; no error response is generated.
REQ-022 In IDLE, s_addr_o, s_wdata_o, s_we_o and m_rdata_o SHALL all be 0.
REQ-023 hold_flag_o SHALL equal (m_req_i[2] & ~m_gnt_o[2]) | (m_req_i[3] & ~m_gnt_o[3]).
REQ-024 A request dropped by a non-owner before it is granted SHALL be ignored; requests are not latched.
REQ-025 If the owner deasserts while others request, the next winner SHALL be chosen in the following IDLE cycle, not on the same edge.

Configuration
REQ-026 Without RIB_RR_EN defined, arbitration SHALL be fixed priority: 0 > 1 > 2 > 3.
REQ-027 With RIB_RR_EN defined, arbitration SHALL be round-robin:
- a 2-bit pointer holds the highest-priority index, and priority descends cyclically from it;
- on every exit from BUSY the pointer is set to owner+1 mod 4.

Reset
REQ-028 rst high SHALL asynchronously force: state IDLE, owner 0, lock counter 0, RR pointer 0.
REQ-029 During reset all outputs SHALL be 0: m_gnt_o, s_we_o, s_addr_o, s_wdata_o, m_rdata_o and hold_flag_o (hold_flag_o once m_req_i settles).
REQ-030 rst asserted mid-transfer SHALL abort the grant immediately with no further s_we_o pulse. After release, arbitration restarts from IDLE on the first edge.

Verification
REQ-031 Bench SHALL apply m_req_i=4'b1100 in IDLE (fixed priority), with m2 addr=0x1000_0004, we=1, wdata=0xDEADBEEF. Required:
- next cycle m_gnt_o=4'b0100, s_we_o=4'b0010, s_wdata_o=0xDEADBEEF;
- hold_flag_o=1 throughout, because m3 is waiting.
REQ-032 Bench SHALL hold m_req_i=4'b0011 continuously with LOCK_MAX=4. Required: m0 is granted for 4 BUSY cycles, then 1 IDLE cycle, then m1 is granted (fixed priority gives m0 again only after m1 releases or is forced off).
REQ-033 Bench SHALL run with RIB_RR_EN, all four masters requesting and each owner dropping its request after 1 BUSY cycle. Required grant order: 0, 1, 2, 3, 0, with an IDLE cycle between each.
REQ-034 Bench SHALL have m3 read address 0x5000_0000 while granted, with s_rdata_i fully non-zero. Required: m_rdata_o=0 and s_we_o=0.
REQ-035 Bench SHALL assert rst for 1 cycle while m1 is in BUSY with we=1. Required: m_gnt_o=0 and s_we_o=0 immediately (same cycle); after rst falls with m1 still requesting, m1 is re-granted 1 cycle later.
